// File: rtl/trace_player_ctrl.sv
// Four-channel trace player: plays string-encoded traces onto A-D
// under start/pause/abort control, with optional looping.
module trace_player_ctrl #(
  parameter logic [32*8-1:0] TRACE_A = {32{"_"}},
  parameter logic [32*8-1:0] TRACE_B = {32{"_"}},
  parameter logic [32*8-1:0] TRACE_C = {32{"_"}},
  parameter logic [32*8-1:0] TRACE_D = {32{"_"}},
  parameter int              LENGTH  = 32,
  parameter int              LOOP    = 0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic [4:0] t,
  output logic       busy,
  output logic       done,
  output logic [7:0] wraps
);

  if (LENGTH < 1 || LENGTH > 32) begin : g_bad_length
    $error("trace_player_ctrl: LENGTH must be in 1..32");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Bit i is set when trace character i (leftmost = 0) is '-'.
  function automatic logic [31:0] f_mask(input logic [32*8-1:0] s);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      m[i] = (s[8*(31-i) +: 8] == 8'h2d);
    end
    return m;
  endfunction

  localparam logic [31:0] MASK_A = f_mask(TRACE_A);
  localparam logic [31:0] MASK_B = f_mask(TRACE_B);
  localparam logic [31:0] MASK_C = f_mask(TRACE_C);
  localparam logic [31:0] MASK_D = f_mask(TRACE_D);
  localparam logic [4:0]  LAST   = 5'(LENGTH - 1);

  state_t     r_state, w_state_nx;
  logic [4:0] r_t, w_t_nx;
  logic [7:0] r_wraps, w_wraps_nx;
  logic       w_run;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      r_wraps <= '0;
    end else begin
      r_state <= w_state_nx;
      r_t     <= w_t_nx;
      r_wraps <= w_wraps_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_t_nx     = r_t;
    w_wraps_nx = r_wraps;
    if (abort) begin
      w_state_nx = S_IDLE;
      w_t_nx     = '0;
    end else if (start) begin
      w_state_nx = S_RUN;
      w_t_nx     = '0;
      w_wraps_nx = '0;
    end else if (r_state == S_RUN && !pause) begin
      if (r_t != LAST) begin
        w_t_nx = r_t + 5'd1;
      end else if (LOOP != 0) begin
        w_t_nx = '0;
        if (r_wraps != 8'hff) begin
          w_wraps_nx = r_wraps + 8'd1;
        end
      end else begin
        w_state_nx = S_DONE;
      end
    end
  end

  assign w_run = (r_state == S_RUN);
  assign A     = w_run & MASK_A[r_t];
  assign B     = w_run & MASK_B[r_t];
  assign C     = w_run & MASK_C[r_t];
  assign D     = w_run & MASK_D[r_t];
  assign t     = r_t;
  assign busy  = w_run;
  assign done  = (r_state == S_DONE);
  assign wraps = r_wraps;

endmodule

// File: tb/tb_trace_player_ctrl.sv
// Scoreboard bench: four configurations share random stimulus and are
// compared each cycle against a string-level reference model.
module tb_trace_player_ctrl;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic abort = 1'b0;

  always #5 clock = ~clock;

  localparam logic [255:0] T0A = {"_-------", {24{"_"}}};
  localparam logic [255:0] T0B = {"-_-_-_-_", {24{"_"}}};
  localparam logic [255:0] T0C = {"--__--__", {24{"-"}}};
  localparam logic [255:0] T0D = {"_______-", {24{"-"}}};
  localparam logic [255:0] T1A = {"-__-", {28{"_"}}};
  localparam logic [255:0] T1B = {"_-_-", {28{"-"}}};
  localparam logic [255:0] T1C = {"--__", {28{"_"}}};
  localparam logic [255:0] T1D = {"___-", {28{"-"}}};
  localparam logic [255:0] T2A = {"_", {31{"-"}}};
  localparam logic [255:0] T2B = {32{"-"}};
  localparam logic [255:0] T2C = {"-", {31{"_"}}};
  localparam logic [255:0] T2D = {32{"_"}};
  localparam logic [255:0] T3A = {16{"-_"}};
  localparam logic [255:0] T3B = {8{"--__"}};
  localparam logic [255:0] T3C = {4{"---_____"}};
  localparam logic [255:0] T3D = {"-", {30{"_"}}, "-"};

  logic       oa [4];
  logic       ob [4];
  logic       oc [4];
  logic       od [4];
  logic [4:0] ot [4];
  logic       obusy [4];
  logic       odone [4];
  logic [7:0] ow [4];

  trace_player_ctrl #(
    .TRACE_A(T0A), .TRACE_B(T0B), .TRACE_C(T0C), .TRACE_D(T0D),
    .LENGTH(8), .LOOP(0)
  ) u0 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .abort(abort), .A(oa[0]), .B(ob[0]), .C(oc[0]), .D(od[0]),
    .t(ot[0]), .busy(obusy[0]), .done(odone[0]), .wraps(ow[0])
  );

  trace_player_ctrl #(
    .TRACE_A(T1A), .TRACE_B(T1B), .TRACE_C(T1C), .TRACE_D(T1D),
    .LENGTH(4), .LOOP(1)
  ) u1 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .abort(abort), .A(oa[1]), .B(ob[1]), .C(oc[1]), .D(od[1]),
    .t(ot[1]), .busy(obusy[1]), .done(odone[1]), .wraps(ow[1])
  );

  trace_player_ctrl #(
    .TRACE_A(T2A), .TRACE_B(T2B), .TRACE_C(T2C), .TRACE_D(T2D),
    .LENGTH(1), .LOOP(1)
  ) u2 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .abort(abort), .A(oa[2]), .B(ob[2]), .C(oc[2]), .D(od[2]),
    .t(ot[2]), .busy(obusy[2]), .done(odone[2]), .wraps(ow[2])
  );

  trace_player_ctrl #(
    .TRACE_A(T3A), .TRACE_B(T3B), .TRACE_C(T3C), .TRACE_D(T3D),
    .LENGTH(32), .LOOP(0)
  ) u3 (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .abort(abort), .A(oa[3]), .B(ob[3]), .C(oc[3]), .D(od[3]),
    .t(ot[3]), .busy(obusy[3]), .done(odone[3]), .wraps(ow[3])
  );

  // Reference model: playing flag, finished flag, position, pass count.
  logic [255:0] tr [4][4];
  int  len  [4] = '{8, 4, 1, 32};
  int  lp   [4] = '{0, 1, 1, 0};
  bit  play [4];
  bit  fin  [4];
  int  pos  [4];
  int  pass [4];

  typedef logic [4*19-1:0] exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;

  function automatic logic hi(int k, int j, int i);
    logic [255:0] s;
    s = tr[k][j];
    return s[8*(31-i) +: 8] == "-";
  endfunction

  task automatic step(input bit r, input bit s, input bit p, input bit a);
    exp_t e;
    logic [18:0] v;
    reset = r;
    start = s;
    pause = p;
    abort = a;
    for (int k = 0; k < 4; k++) begin
      if (r) begin
        play[k] = 0; fin[k] = 0; pos[k] = 0; pass[k] = 0;
      end else if (a) begin
        play[k] = 0; fin[k] = 0; pos[k] = 0;
      end else if (s) begin
        play[k] = 1; fin[k] = 0; pos[k] = 0; pass[k] = 0;
      end else if (play[k] && !p) begin
        if (pos[k] + 1 < len[k]) begin
          pos[k] = pos[k] + 1;
        end else if (lp[k] != 0) begin
          pos[k] = 0;
          if (pass[k] < 255) pass[k] = pass[k] + 1;
        end else begin
          play[k] = 0;
          fin[k] = 1;
        end
      end
      v = {play[k] && hi(k, 0, pos[k]), play[k] && hi(k, 1, pos[k]),
           play[k] && hi(k, 2, pos[k]), play[k] && hi(k, 3, pos[k]),
           5'(pos[k]), play[k], fin[k], 8'(pass[k])};
      e[k*19 +: 19] = v;
    end
    q.push_back(e);
  endtask

  task automatic cyc(input bit r, input bit s, input bit p, input bit a,
                     input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      step(r, s, p, a);
    end
  endtask

  initial begin
    exp_t e;
    logic [18:0] g;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int k = 0; k < 4; k++) begin
          g = {oa[k], ob[k], oc[k], od[k], ot[k], obusy[k], odone[k], ow[k]};
          checks++;
          if (g !== e[k*19 +: 19]) begin
            errors++;
            $display("FAIL inst%0d @%0t got=%h exp=%h", k, $time, g,
                     e[k*19 +: 19]);
          end
        end
      end
    end
  end

  initial begin
    tr[0] = '{T0A, T0B, T0C, T0D};
    tr[1] = '{T1A, T1B, T1C, T1D};
    tr[2] = '{T2A, T2B, T2C, T2D};
    tr[3] = '{T3A, T3B, T3C, T3D};
    cyc(1, 0, 0, 0, 2);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 40);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 0, 1, 0, 3);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 1, 1, 0, 1);
    cyc(0, 0, 0, 0, 5);
    cyc(0, 0, 0, 1, 1);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 1, 0, 1, 1);
    cyc(0, 0, 0, 0, 2);
    cyc(0, 1, 0, 0, 1);
    cyc(0, 0, 0, 0, 300);
    cyc(0, 0, 0, 1, 1);
    for (int i = 0; i < 2000; i++) begin
      @(negedge clock);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) < 4,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 2);
    end
    repeat (3) @(posedge clock);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d left exp=0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_player_ctrl.md
# trace_player_ctrl

Controller for four-channel trace stimulus used by the SVA regression benches. It plays parameter-string traces onto outputs A–D under start, pause and abort control, with an optional loop mode. It replaces the free-running trace counter so that property checks (until / until_with / .triggered) can be armed at a chosen cycle, repeated, and cut short mid-trace. It sits between the bench clock and the DUT property wires A–D.

## Interface
Parameters:
- TRACE_A / TRACE_B / TRACE_C / TRACE_D, default 32 × "_", [32*8-1:0] strings. Character i (leftmost = index 0) is "-" for high; any other character is low.
- LENGTH, default 32, number of trace characters played, legal range 1..32.
- LOOP, default 0. 1 = wrap to index 0 after index LENGTH-1 instead of finishing.

Ports:
- clock  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- start  in  1  (re)start playback at index 0.
- pause  in  1  level; freezes the index while RUN.
- abort  in  1  return to IDLE immediately.
- A, B, C, D  out  1 each  trace values, combinational from state and index.
- t  out  5  current trace index.
- busy  out  1  state == RUN.
- done  out  1  state == DONE.
- wraps  out  8  completed loop passes, saturating at 255.

## Operation
- States: IDLE, RUN, DONE. Encoding is free.
- Input priority, evaluated at each posedge: reset > abort > start > pause > normal advance.
- reset: state = IDLE, t = 0, wraps = 0.
- abort, any state: state = IDLE, t = 0; wraps is held.
- IDLE: A–D = 0. start → RUN, t = 0, wraps = 0.
- RUN, pause = 1: t holds and A–D keep showing index t.
- RUN, pause = 0, t < LENGTH-1: t = t+1.
- RUN, pause = 0, t == LENGTH-1:
  - LOOP = 1: t = 0, wraps = wraps+1 (saturating), stay RUN.
  - LOOP = 0: state = DONE, t holds at LENGTH-1.
- RUN, start = 1: restart. t = 0, wraps = 0, stay RUN; overrides pause.
- DONE: A–D = 0, done = 1. start → RUN, t = 0, wraps = 0.
- Output decode: in RUN, A = (TRACE_A[8*(31-t) +: 8] == "-"), and likewise for B–D. In IDLE and DONE, A–D = 0.
- LENGTH = 1: each unpaused RUN cycle is the final index.
- LENGTH outside 1..32 is a configuration error and is flagged at elaboration.

## Timing
- Reset values: state IDLE, t = 0, wraps = 0, A–D = 0, busy = 0, done = 0.
- start sampled at edge k:
  - cycle after edge k: busy = 1, t = 0, A–D = character 0.
  - Non-loop, no pause: character LENGTH-1 is shown in the cycle after edge k+LENGTH-1; done rises after edge k+LENGTH.
  - Total busy time is LENGTH cycles plus the number of paused cycles.
- Loop: index 0 follows index LENGTH-1 with no gap; wraps increments on the same edge as the wrap.
- abort or reset mid-run: outputs drop to 0 in the very next cycle; there is no drain.
- start and abort on the same edge: abort wins, state = IDLE.
- start and pause on the same edge in RUN: restart to t = 0 wins.

## Test plan
- LENGTH=8, LOOP=0, TRACE_A="_-------…", start at cycle 2 → busy cycles 3..10, A high cycles 4..10, done from cycle 11, t = 7 in DONE.
- LENGTH=4, LOOP=1, run 13 cycles → t sequence 0,1,2,3,0,…; wraps = 3 after the third wrap; done never asserts.
- LENGTH=8, pause high for 3 cycles while t = 2 → t stays 2 for 4 cycles and A–D hold; done arrives 3 cycles later than in the unpaused case.
- abort at t = 5 → next cycle IDLE, A–D = 0, t = 0; a later start replays from index 0.
- start re-asserted at t = 4 together with pause → next cycle t = 0, wraps = 0, busy = 1.
- LENGTH=1, LOOP=1, TRACE_B="-…" → B constant 1 while running; wraps increments every cycle and saturates at 255.
